// File: rtl/u_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its watchdog.
package u_hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_ERR  = 2'd3
  } hz_state_t;

  localparam int HZ_WD_W   = 8;
  localparam int HZ_WD_MAX = 255;
  localparam int HZ_BR_W   = 3;

  // Bit positions of the hazard causes, lowest index wins.
  localparam int HZ_PRI_MEM = 0;
  localparam int HZ_PRI_LU  = 1;
  localparam int HZ_PRI_TK  = 2;
  localparam int HZ_PRI_BRW = 3;
  localparam int HZ_PRI_N   = 4;

  function automatic logic [HZ_WD_W-1:0] hz_clamp_to(input int to);
    return (to > HZ_WD_MAX) ? HZ_WD_W'(HZ_WD_MAX) : HZ_WD_W'(to);
  endfunction

endpackage

// File: rtl/u_hazard_wdog.sv
// Bus-wait watchdog: start loads 1, clr zeroes, otherwise a running count
// advances until it reaches limit-1, where expired is raised and the count holds.
module u_hazard_wdog (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              clr,
  input  logic [u_hazard_pkg::HZ_WD_W-1:0]  limit,
  output logic                              expired
);
  import u_hazard_pkg::*;

  logic [HZ_WD_W-1:0] cnt_reg;

  assign expired = (cnt_reg != '0) && (cnt_reg == limit - HZ_WD_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= HZ_WD_W'(1);
    end else if ((cnt_reg != '0) && !expired) begin
      cnt_reg <= cnt_reg + HZ_WD_W'(1);
    end
  end

endmodule

// File: rtl/u_hazard_ctrl.sv
// RV32 pipeline hazard controller: stalls/flushes for IF, p1, p2, p3.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module u_hazard_ctrl #(
  parameter int MEM_TO   = 64,
  parameter int BR_FLUSH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        branch,
  input  logic        fwd_no_dat,
  input  logic        lsu_req,
  input  logic        lsu_vld,
  output logic        stall_if,
  output logic        stall0,
  output logic        stall1,
  output logic        stall2,
  output logic        flush0,
  output logic        flush1,
  output logic        flush_if,
  output logic        mem_err,
  output logic [1:0]  hz_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);
  import u_hazard_pkg::*;

  localparam logic [HZ_WD_W-1:0] WD_LIMIT  = hz_clamp_to(MEM_TO);
  localparam logic [HZ_BR_W-1:0] BR_RELOAD = HZ_BR_W'(BR_FLUSH - 1);
  localparam bit                 BR_WIN    = (BR_FLUSH > 1);

  hz_state_t            state_reg, state_next;
  logic [HZ_BR_W-1:0]   br_cnt_reg, br_cnt_next;
  logic                 mem_err_reg, mem_err_next;
  logic                 wd_start, wd_clr, wd_expired;
  logic [HZ_PRI_N-1:0]  cause;
  logic                 mem_wait, hold_all;

  u_hazard_wdog u_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .start   (wd_start),
    .clr     (wd_clr),
    .limit   (WD_LIMIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      br_cnt_reg  <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      br_cnt_reg  <= br_cnt_next;
      mem_err_reg <= mem_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    br_cnt_next  = br_cnt_reg;
    mem_err_next = mem_err_reg;
    wd_start     = 1'b0;
    wd_clr       = 1'b0;

    // A completing access always beats a new request in the same cycle.
    mem_wait = ((state_reg == MEM_WAIT) && !lsu_vld) ||
               ((state_reg != MEM_ERR) && lsu_req && !lsu_vld);
    hold_all = mem_wait || (state_reg == MEM_ERR);

    cause             = '0;
    cause[HZ_PRI_MEM] = hold_all;
    cause[HZ_PRI_LU]  = fwd_no_dat && !hold_all;
    cause[HZ_PRI_TK]  = branch && !fwd_no_dat && !hold_all;
    cause[HZ_PRI_BRW] = (state_reg == u_hazard_pkg::BR_FLUSH) &&
                        (br_cnt_reg != '0) && !hold_all;

    if (state_reg == MEM_ERR) begin
      state_next = MEM_ERR;
    end else if (mem_wait) begin
      // br_cnt is left untouched so the flush window resumes after the wait.
      if (state_reg == MEM_WAIT) begin
        if (wd_expired) begin
          state_next   = MEM_ERR;
          mem_err_next = 1'b1;
        end
      end else begin
        state_next = MEM_WAIT;
        wd_start   = 1'b1;
      end
    end else begin
      wd_clr = 1'b1;
      if (cause[HZ_PRI_TK] && BR_WIN) begin
        br_cnt_next = BR_RELOAD;
      end else if (cause[HZ_PRI_BRW]) begin
        br_cnt_next = br_cnt_reg - HZ_BR_W'(1);
      end
      state_next = (br_cnt_next != '0) ? u_hazard_pkg::BR_FLUSH : IDLE;
    end
  end

  // Outputs are forced low for as long as rstn is held.
  assign stall_if = rstn && (cause[HZ_PRI_MEM] || cause[HZ_PRI_LU]);
  assign stall0   = rstn && (cause[HZ_PRI_MEM] || cause[HZ_PRI_LU]);
  assign stall1   = rstn && cause[HZ_PRI_MEM];
  assign stall2   = rstn && cause[HZ_PRI_MEM];
  assign flush0   = rstn && cause[HZ_PRI_TK];
  assign flush1   = rstn && cause[HZ_PRI_LU];
  assign flush_if = rstn && (cause[HZ_PRI_TK] || cause[HZ_PRI_BRW]);
  assign mem_err  = rstn && mem_err_reg;
  assign hz_state = state_reg;

  a_no_flush_stall0: assert property (@(posedge clk) disable iff (!rstn) !(flush0 && stall0));
  a_no_flush_stall1: assert property (@(posedge clk) disable iff (!rstn) !(flush1 && stall1));

`ifdef HAZARD_PERF_CNT_EN
  logic [1:0] perf_inc;
  assign perf_inc = {flush0 || flush1, stall0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign perf_stall = g_perf[0].cnt_reg;
  assign perf_flush = g_perf[1].cnt_reg;
`endif

endmodule

// File: doc/u_hazard_ctrl.md
Name: u_hazard_ctrl

Overview:
- Pipeline hazard controller for the RV32 core. Generates every stall and flush control for fetch, decode->exe (p1), exe->mem (p2) and mem->wb (p3).
- Inputs: taken-branch, missing-forward-data and LSU handshake status.
- Sequences memory waits with a bounded watchdog, inserts load-use bubbles, and holds a fetch flush window after taken branches.
- Sits beside u_exe and the IFU; all outputs are combinational from registered state plus current-cycle inputs.

Parameters:
- MEM_TO, 64: LSU wait watchdog limit in cycles, range 2..255.
- BR_FLUSH, 2: cycles flush_if stays asserted per taken branch, including the branch cycle, range 1..7.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- branch  in  1  taken branch/jump resolved in p1 this cycle
- fwd_no_dat  in  1  p1 source operand not yet available (load in flight)
- lsu_req  in  1  p2 holds a valid load/store (|lsu_re or |lsu_we)
- lsu_vld  in  1  LSU completes the p2 access this cycle
- stall_if  out  1  hold PC/fetch
- stall0  out  1  hold p1 registers
- stall1  out  1  hold p2 registers
- stall2  out  1  hold p3 registers
- flush0  out  1  clear p1 instruction-type flags
- flush1  out  1  clear p2 (bubble)
- flush_if  out  1  kill fetched/decoded instruction(s); IFU redirects to branch target
- mem_err  out  1  sticky: LSU watchdog expired
- hz_state  out  2  current FSM state (debug)

Behaviour:
- Reset: rstn low asynchronously forces FSM to IDLE, both counters to 0 and mem_err to 0. All outputs read 0 while in reset.
- FSM states: IDLE=0, MEM_WAIT=1, BR_FLUSH=2, MEM_ERR=3.
- IDLE:
  - lsu_req & !lsu_vld -> MEM_WAIT; wd_cnt := 1.
  - Else branch & !fwd_no_dat & BR_FLUSH>1 -> BR_FLUSH; br_cnt := BR_FLUSH-1.
  - Else stay in IDLE.
- MEM_WAIT:
  - lsu_vld -> IDLE.
  - Else if wd_cnt == MEM_TO-1 -> MEM_ERR and set mem_err.
  - Else wd_cnt += 1.
- BR_FLUSH:
  - Decrement br_cnt; reaching 0 -> IDLE.
  - A new taken branch reloads br_cnt := BR_FLUSH-1.
  - lsu_req & !lsu_vld has priority: go to MEM_WAIT. The remaining flush window is preserved in br_cnt and resumed after the wait.
- MEM_ERR: terminal. stall_if/stall0/stall1/stall2 held at 1 until reset.
- Output equations, evaluated in priority order:
  1. mem_wait = (state==MEM_WAIT & !lsu_vld) | (state!=MEM_ERR & lsu_req & !lsu_vld). Drives stall_if=stall0=stall1=stall2=1. No flush is asserted and branch is ignored this cycle.
  2. load-use = fwd_no_dat & !mem_wait. Drives stall_if=1, stall0=1, flush1=1 (bubble into p2), and branch is ignored because operands are invalid.
  3. taken = branch & !fwd_no_dat & !mem_wait. Drives flush0=1, flush_if=1.
  4. state==BR_FLUSH & br_cnt!=0 & !mem_wait: flush_if=1.
- A flush must never coincide with a stall of the same register. Assertion: !(flush0 & stall0), !(flush1 & stall1).
- Simultaneous lsu_vld and a new lsu_req on the same cycle: completion wins. No stall that cycle, FSM stays IDLE.
- Watchdog counter is 8 bits wide; MEM_TO is clamped to 255.
- Outputs have zero latency from inputs; only state transitions are registered.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_stall (32-bit) and perf_flush (32-bit).
  - perf_stall increments on each cycle with stall0=1.
  - perf_flush increments on each cycle with flush0=1 or flush1=1.
  - Both wrap at 2^32 and reset to 0.
- When undefined, the ports do not exist and no counter logic is present.

Decomposition:
- Package u_hazard_pkg holds:
  - typedef enum logic [1:0] hz_state_t {IDLE, MEM_WAIT, BR_FLUSH, MEM_ERR};
  - localparam HZ_WD_W = 8;
  - priority-encoding constants.
- Sub-module u_hazard_wdog: 8-bit load/increment/compare watchdog with inputs start, clr and limit, and output expired. Reused by the future IFU bus wait.

Test Plan:
- Load miss: lsu_req=1 with lsu_vld low for 3 cycles, then high. Stall_if/0/1/2=1 for exactly 3 cycles, all 0 on the vld cycle; hz_state goes 1 then 0.
- Load-use: fwd_no_dat=1 for 1 cycle with branch=1 on the same cycle. stall_if=stall0=flush1=1, flush0=flush_if=0; next cycle all 0.
- Taken branch, BR_FLUSH=2: branch pulse at cycle N. flush0=1 and flush_if=1 at N; flush_if=1 at N+1; all 0 at N+2.
- Branch then memory wait: branch at N, lsu_req & !lsu_vld at N+1 for 2 cycles. Stalls during the wait; flush_if resumes for 1 cycle after lsu_vld.
- Watchdog, MEM_TO=4: lsu_req=1 with lsu_vld=0 held. mem_err=1 after 4 cycles, hz_state=3, stalls stay 1. Asynchronous rstn low mid-cycle clears everything immediately.
- HAZARD_PERF_CNT_EN: run the scenarios above. perf_stall and perf_flush equal the summed cycle counts; 0 after reset.
